usr_sequencer: RTL and testbench

USR_SEQUENCER -- requirements
Module: usr_sequencer

---
 rtl/usr_pkg.sv | 29 ++
 rtl/usr_sequencer.sv | 92 +++++++++
 tb/tb_usr_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared command opcodes, shift-register mode codes and sequencer states.
package usr_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROT  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b100,
        M_LOAD = 3'b010,
        M_ROT  = 3'b011
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_EXEC    = 2'b01,
        S_CAPTURE = 2'b10
    } state_t;

    function automatic mode_t op_mode(input op_t op);
        return op == OP_LOAD ? M_LOAD : op == OP_SHR ? M_SHR : op == OP_SHL ? M_SHL : M_ROT;
    endfunction

endpackage

// File: rtl/usr_sequencer.sv
// usr_sequencer: drives a 4-bit universal shift register through LOAD/SHR/SHL/ROT
// commands and captures its Q once each command completes.
module usr_sequencer
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_count,
    input  logic [3:0] cmd_data,
    input  logic [3:0] q_in,
    output logic [2:0] mode,
    output logic       data_in,
    output logic       parallel_in_0,
    output logic       parallel_in_1,
    output logic       parallel_in_2,
    output logic       parallel_in_3,
    output logic       busy,
    output logic       done,
    output logic [3:0] result
);

    state_t     r_state;
    state_t     w_next;
    op_t        r_op;
    logic [3:0] r_data;
    logic [2:0] r_cnt;
    logic [1:0] r_step;
    logic       r_ready;
    logic       r_done;
    logic [3:0] r_result;
    logic       w_accept;
    logic       w_skip;
    logic [3:0] w_par;

    assign w_accept = cmd_valid & r_ready;
    assign w_skip   = op_t'(cmd_op) != OP_LOAD && cmd_count == 3'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == S_IDLE ? (w_accept ? (w_skip ? S_CAPTURE : S_EXEC) : S_IDLE) :
                 r_state == S_EXEC ? (r_cnt == 3'd0 ? S_CAPTURE : S_EXEC) : S_IDLE;
    end

    // r_cnt holds the EXEC cycles remaining after the current one; LOAD always gets one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_LOAD;
            r_data   <= 4'b0;
            r_cnt    <= 3'd0;
            r_step   <= 2'd0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 4'b0;
        end else begin
            r_ready <= w_next == S_IDLE;
            r_done  <= r_state == S_CAPTURE;
            if (r_state == S_CAPTURE)
                r_result <= q_in;
            if (w_accept) begin
                r_op   <= op_t'(cmd_op);
                r_data <= cmd_data;
                r_cnt  <= (op_t'(cmd_op) == OP_LOAD || w_skip) ? 3'd0 : cmd_count - 3'd1;
                r_step <= 2'd0;
            end else if (r_state == S_EXEC) begin
                r_cnt  <= r_cnt == 3'd0 ? 3'd0 : r_cnt - 3'd1;
                r_step <= r_step + 2'd1;
            end
        end
    end

    always_comb begin
        mode      = r_state == S_EXEC ? op_mode(r_op) : M_HOLD;
        data_in   = r_state == S_EXEC ? r_data[r_step] : 1'b0;
        w_par     = (r_state == S_EXEC && r_op == OP_LOAD) ? r_data : 4'b0;
        busy      = r_state != S_IDLE;
        cmd_ready = r_ready;
        done      = r_done;
        result    = r_result;
    end

    assign {parallel_in_3, parallel_in_2, parallel_in_1, parallel_in_0} = w_par;

endmodule

// File: tb/tb_usr_sequencer.sv
// tb_usr_sequencer: usr_sequencer paired with a behavioural universal shift register;
// expected completions are queued by the driver and checked by a done monitor.
module tb_usr_sequencer;

    typedef struct {
        logic [3:0] res;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_count = 3'd0;
    logic [3:0] cmd_data = 4'b0;
    logic [3:0] q = 4'b0;
    logic [2:0] mode;
    logic       data_in;
    logic       p0, p1, p2, p3;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    usr_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .q_in(q),
        .mode(mode), .data_in(data_in),
        .parallel_in_0(p0), .parallel_in_1(p1), .parallel_in_2(p2), .parallel_in_3(p3),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register: shift right enters at Q[3], rotate is rightward.
    always @(posedge clk) begin
        case (mode)
            3'b010:  q <= {p3, p2, p1, p0};
            3'b001:  q <= {data_in, q[3:1]};
            3'b100:  q <= {q[2:0], data_in};
            3'b011:  q <= {q[0], q[3:1]};
            default: q <= q;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic wait_ready(input string name);
        int i;
        for (i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) chk(name, 0, 1);
    endtask

    task automatic run(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] d,
                       input logic [3:0] res);
        int nexec;
        logic [2:0] m;
        exp_t e;
        nexec = op == 2'b00 ? 1 : int'(cnt);
        m = op == 2'b00 ? 3'b010 : op == 2'b01 ? 3'b001 : op == 2'b10 ? 3'b100 : 3'b011;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = d;
        wait_ready("accept_timeout");
        e.res = res; e.lat = op == 2'b00 ? 3 : int'(cnt) + 2; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        for (int k = 0; k < nexec; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("exec_mode", mode, m);
            chk("exec_data_in", data_in, d[k % 4]);
            chk("exec_parallel", {p3, p2, p1, p0}, op == 2'b00 ? d : 4'b0);
            chk("exec_ready", cmd_ready, 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("capture_mode", mode, 0);
        chk("capture_busy", busy, 1);
        @(negedge clk);
        chk("done_cycle_ready", cmd_ready, 1);
        chk("done_cycle_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mode", mode, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_parallel", {p3, p2, p1, p0}, 0);
        chk("rst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        run(2'b00, 3'd0, 4'b0101, 4'b0101);
        run(2'b00, 3'd0, 4'b0000, 4'b0000);
        run(2'b01, 3'd3, 4'b0101, 4'b1010);
        run(2'b00, 3'd0, 4'b0101, 4'b0101);
        run(2'b11, 3'd4, 4'b1001, 4'b0101);
        run(2'b10, 3'd0, 4'b1111, 4'b0101);

        // back-to-back: valid stays high, fields change while busy
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_count = 3'd0; cmd_data = 4'b1111;
        wait_ready("b2b_first_timeout");
        e.res = 4'b1111; e.lat = 3; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_op = 2'b10; cmd_count = 3'd2; cmd_data = 4'b0000;
        #1;
        chk("b2b_busy_ready", cmd_ready, 0);
        chk("b2b_load_parallel", {p3, p2, p1, p0}, 4'b1111);
        @(negedge clk);
        chk("b2b_not_taken_ready", cmd_ready, 0);
        @(negedge clk);
        wait_ready("b2b_second_timeout");
        chk("b2b_accept_on_done", done, 1);
        e.res = 4'b1100; e.lat = 4; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_shl_mode", mode, 3'b100);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("b2b_drain", exp_q.size(), 0);

        // reset during a long shift aborts it without done
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 3'd7; cmd_data = 4'b1111;
        wait_ready("abort_accept_timeout");
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_mode_before", mode, 3'b001);
        #2 reset = 1'b1;
        #1;
        chk("abort_mode", mode, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", cmd_ready, 1);
        repeat (10) @(negedge clk);
        chk("abort_no_done_result", result, 0);

        run(2'b00, 3'd0, 4'b0011, 4'b0011);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
